// File: rtl/mac_pkg.sv
// Shared types and constants for the FP32 MAC operand path.
// Operands are treated as opaque 32-bit patterns.
package mac_pkg;

  localparam int FP_WIDTH = 32;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_11_375 = 32'h41360000;
  localparam fp32_t FP32_5_563  = 32'h40B20419;

endpackage

// File: rtl/mac_operand_feeder_if.sv
// Pair handshake between the operand feeder and the MAC.
// The master presents pairs; the slave returns ready.
interface mac_operand_feeder_if #(
  parameter int WIDTH = 32,
  parameter int TAPS  = 4
);

  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic             pair_valid;
  logic             pair_ready;
  logic [WIDTH-1:0] signal_out;
  logic [WIDTH-1:0] coeff_out;
  logic             pair_last;
  logic [TW-1:0]    tap_idx;

  modport master (
    output pair_valid,
    output signal_out,
    output coeff_out,
    output pair_last,
    output tap_idx,
    input  pair_ready
  );

  modport slave (
    input  pair_valid,
    input  signal_out,
    input  coeff_out,
    input  pair_last,
    input  tap_idx,
    output pair_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit occupancy counter.
// A write to a full FIFO is dropped even if a pop happens alongside.
module sync_fifo
  import mac_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       wr_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign wr_drop = wr_en && full;
  assign rd_data = mem[rd_ptr];
  assign count   = cnt;

  // Pointer and occupancy bookkeeping; clear empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
    end
  end

  // Storage array; contents are irrelevant outside the occupied window.
  always_ff @(posedge clk) begin
    if (push && !rst && !clr)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Pairs signal samples with coefficients for the FP32 MAC.
// Tracks the tap position and a sticky overflow flag.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int DEPTH = 8,
  parameter int TAPS  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       sig_wr_en,
  input  logic [WIDTH-1:0]           sig_wr_data,
  input  logic                       coef_wr_en,
  input  logic [WIDTH-1:0]           coef_wr_data,
  output logic                       sig_full,
  output logic                       coef_full,
  output logic [$clog2(DEPTH+1)-1:0] sig_count,
  output logic [$clog2(DEPTH+1)-1:0] coef_count,
  output logic                       overflow,
  mac_operand_feeder_if.master       pair_if
);

  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic          sig_empty;
  logic          coef_empty;
  logic          sig_drop;
  logic          coef_drop;
  logic          pop;
  logic [TW-1:0] tap_q;
  logic          ovf_q;

  assign pair_if.pair_valid = !sig_empty && !coef_empty;
  assign pop = pair_if.pair_valid && pair_if.pair_ready;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_sig_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr_en   (sig_wr_en),
    .wr_data (sig_wr_data),
    .rd_en   (pop),
    .rd_data (pair_if.signal_out),
    .count   (sig_count),
    .full    (sig_full),
    .empty   (sig_empty),
    .wr_drop (sig_drop)
  );

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_coef_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr_en   (coef_wr_en),
    .wr_data (coef_wr_data),
    .rd_en   (pop),
    .rd_data (pair_if.coeff_out),
    .count   (coef_count),
    .full    (coef_full),
    .empty   (coef_empty),
    .wr_drop (coef_drop)
  );

  // Tap counter: advance per accepted pair, wrap after the last tap.
  always_ff @(posedge clk) begin
    if (rst || flush)
      tap_q <= '0;
    else if (pop)
      tap_q <= (tap_q == TW'(TAPS - 1)) ? '0 : tap_q + 1'b1;
  end

  // Sticky overflow; writes during flush are ignored, so they cannot set it.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (!flush && (sig_drop || coef_drop))
      ovf_q <= 1'b1;
  end

  assign pair_if.tap_idx   = tap_q;
  assign pair_if.pair_last = (tap_q == TW'(TAPS - 1));
  assign overflow          = ovf_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Randomized bench for mac_operand_feeder with a queue-based model.
// Each scenario task checks the DUT against the model inline.
module tb_mac_operand_feeder;
  import mac_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int TAPS  = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int TW    = $clog2(TAPS);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             sig_wr_en;
  logic [WIDTH-1:0] sig_wr_data;
  logic             coef_wr_en;
  logic [WIDTH-1:0] coef_wr_data;
  logic             sig_full;
  logic             coef_full;
  logic [CW-1:0]    sig_count;
  logic [CW-1:0]    coef_count;
  logic             overflow;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] sq[$];
  logic [WIDTH-1:0] cq[$];
  int               m_tap;
  bit               m_ovf;

  mac_operand_feeder_if #(.WIDTH(WIDTH), .TAPS(TAPS)) u_if ();

  mac_operand_feeder #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .TAPS  (TAPS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .sig_wr_en    (sig_wr_en),
    .sig_wr_data  (sig_wr_data),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_data (coef_wr_data),
    .sig_full     (sig_full),
    .coef_full    (coef_full),
    .sig_count    (sig_count),
    .coef_count   (coef_count),
    .overflow     (overflow),
    .pair_if      (u_if.master)
  );

  always #5 clk = ~clk;

  function automatic bit m_pv();
    return sq.size() != 0 && cq.size() != 0;
  endfunction

  // Advance model by one edge using the currently driven inputs, then clock.
  task automatic tick();
    bit pop;
    pop = m_pv() && u_if.pair_ready;
    if (rst) begin
      sq.delete(); cq.delete(); m_tap = 0; m_ovf = 0;
    end else if (flush) begin
      sq.delete(); cq.delete(); m_tap = 0;
    end else begin
      if (sig_wr_en) begin
        if (sq.size() == DEPTH) m_ovf = 1;
        else sq.push_back(sig_wr_data);
      end
      if (coef_wr_en) begin
        if (cq.size() == DEPTH) m_ovf = 1;
        else cq.push_back(coef_wr_data);
      end
      if (pop) begin
        void'(sq.pop_front());
        void'(cq.pop_front());
        m_tap = (m_tap + 1) % TAPS;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0;
    sig_wr_en = 0; coef_wr_en = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic fill(input int n);
    u_if.pair_ready = 0;
    for (int i = 0; i < n; i++) begin
      sig_wr_en = 1; sig_wr_data = $urandom;
      coef_wr_en = 1; coef_wr_data = $urandom;
      tick();
    end
    sig_wr_en = 0; coef_wr_en = 0;
  endtask

  task automatic test_reset();
    u_if.pair_ready = 0;
    do_reset();
    total++; if (sig_count !== '0) begin bad++;
      $display("FAIL reset_sig_count got=%0d exp=0", sig_count); end
    total++; if (coef_count !== '0) begin bad++;
      $display("FAIL reset_coef_count got=%0d exp=0", coef_count); end
    total++; if ({sig_full, coef_full} !== 2'b00) begin bad++;
      $display("FAIL reset_full got=%b exp=00", {sig_full, coef_full}); end
    total++; if (u_if.pair_valid !== 1'b0) begin bad++;
      $display("FAIL reset_valid got=%b exp=0", u_if.pair_valid); end
    total++; if (u_if.tap_idx !== '0 || u_if.pair_last !== 1'b0) begin bad++;
      $display("FAIL reset_tap got=%0d/%b exp=0/0", u_if.tap_idx, u_if.pair_last); end
    total++; if (overflow !== 1'b0) begin bad++;
      $display("FAIL reset_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_first_pair();
    u_if.pair_ready = 1;
    sig_wr_en = 1; sig_wr_data = FP32_11_375;
    tick();
    sig_wr_en = 0;
    total++; if (u_if.pair_valid !== 1'b0) begin bad++;
      $display("FAIL first_valid_early got=%b exp=0", u_if.pair_valid); end
    coef_wr_en = 1; coef_wr_data = FP32_5_563;
    tick();
    coef_wr_en = 0;
    total++; if (u_if.pair_valid !== 1'b1) begin bad++;
      $display("FAIL first_valid got=%b exp=1", u_if.pair_valid); end
    total++; if (u_if.signal_out !== FP32_11_375) begin bad++;
      $display("FAIL first_sig got=%h exp=%h", u_if.signal_out, FP32_11_375); end
    total++; if (u_if.coeff_out !== FP32_5_563) begin bad++;
      $display("FAIL first_coef got=%h exp=%h", u_if.coeff_out, FP32_5_563); end
    total++; if (u_if.tap_idx !== '0) begin bad++;
      $display("FAIL first_tap got=%0d exp=0", u_if.tap_idx); end
    tick();
    total++; if (u_if.pair_valid !== 1'b0 || sig_count !== '0) begin bad++;
      $display("FAIL first_consumed got=%b/%0d exp=0/0", u_if.pair_valid, sig_count); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    fill(DEPTH);
    total++; if ({sig_full, coef_full} !== 2'b11) begin bad++;
      $display("FAIL fill_full got=%b exp=11", {sig_full, coef_full}); end
    total++; if (sig_count !== CW'(8) || coef_count !== CW'(8)) begin bad++;
      $display("FAIL fill_count got=%0d/%0d exp=8/8", sig_count, coef_count); end
    total++; if (overflow !== 1'b0) begin bad++;
      $display("FAIL fill_ovf_early got=%b exp=0", overflow); end
    sig_wr_en = 1; sig_wr_data = $urandom;
    tick();
    sig_wr_en = 0;
    total++; if (overflow !== 1'b1 || sig_count !== CW'(8)) begin bad++;
      $display("FAIL ovf_set got=%b/%0d exp=1/8", overflow, sig_count); end
    total++; if (u_if.signal_out !== sq[0]) begin bad++;
      $display("FAIL ovf_head got=%h exp=%h", u_if.signal_out, sq[0]); end
  endtask

  task automatic test_full_pop_write();
    logic [WIDTH-1:0] second;
    do_reset();
    fill(DEPTH);
    second = sq[1];
    u_if.pair_ready = 1;
    sig_wr_en = 1; sig_wr_data = $urandom;
    tick();
    sig_wr_en = 0; u_if.pair_ready = 0;
    total++; if (sig_count !== CW'(7) || coef_count !== CW'(7)) begin bad++;
      $display("FAIL fpw_count got=%0d/%0d exp=7/7", sig_count, coef_count); end
    total++; if (overflow !== 1'b1) begin bad++;
      $display("FAIL fpw_ovf got=%b exp=1", overflow); end
    total++; if (u_if.signal_out !== second) begin bad++;
      $display("FAIL fpw_head got=%h exp=%h", u_if.signal_out, second); end
  endtask

  task automatic test_stream_taps();
    do_reset();
    fill(DEPTH);
    u_if.pair_ready = 1;
    for (int k = 0; k < 8; k++) begin
      total++; if (u_if.pair_valid !== 1'b1 || u_if.tap_idx !== TW'(k % 4)) begin bad++;
        $display("FAIL tap_idx k=%0d got=%b/%0d exp=1/%0d", k, u_if.pair_valid, u_if.tap_idx, k % 4); end
      total++; if (u_if.pair_last !== (k % 4 == 3)) begin bad++;
        $display("FAIL tap_last k=%0d got=%b exp=%b", k, u_if.pair_last, k % 4 == 3); end
      total++; if (u_if.signal_out !== sq[0] || u_if.coeff_out !== cq[0]) begin bad++;
        $display("FAIL tap_data k=%0d got=%h/%h exp=%h/%h", k, u_if.signal_out, u_if.coeff_out, sq[0], cq[0]); end
      tick();
    end
    total++; if (u_if.pair_valid !== 1'b0) begin bad++;
      $display("FAIL tap_drain got=%b exp=0", u_if.pair_valid); end
  endtask

  task automatic test_stall();
    bit pat[4] = '{1, 0, 0, 1};
    bit stalled = 0;
    logic [WIDTH-1:0] ps, pc;
    logic [TW-1:0] pt;
    logic pl;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      u_if.pair_ready = pat[i % 4];
      sig_wr_en = ($urandom_range(0, 2) != 0); sig_wr_data = $urandom;
      coef_wr_en = ($urandom_range(0, 2) != 0); coef_wr_data = $urandom;
      if (stalled) begin
        total++; if (u_if.signal_out !== ps || u_if.coeff_out !== pc ||
                     u_if.tap_idx !== pt || u_if.pair_last !== pl) begin bad++;
          $display("FAIL stall_hold i=%0d got=%h/%h/%0d exp=%h/%h/%0d", i,
                   u_if.signal_out, u_if.coeff_out, u_if.tap_idx, ps, pc, pt); end
      end
      total++; if (u_if.pair_valid !== m_pv()) begin bad++;
        $display("FAIL stall_valid i=%0d got=%b exp=%b", i, u_if.pair_valid, m_pv()); end
      if (m_pv()) begin
        total++; if (u_if.signal_out !== sq[0] || u_if.coeff_out !== cq[0]) begin bad++;
          $display("FAIL stall_data i=%0d got=%h/%h exp=%h/%h", i, u_if.signal_out, u_if.coeff_out, sq[0], cq[0]); end
      end
      stalled = m_pv() && !u_if.pair_ready;
      ps = u_if.signal_out; pc = u_if.coeff_out;
      pt = u_if.tap_idx; pl = u_if.pair_last;
      tick();
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    fill(DEPTH);
    sig_wr_en = 1; sig_wr_data = $urandom;
    tick();
    sig_wr_en = 0;
    u_if.pair_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    fill(1);
    total++; if (u_if.tap_idx !== TW'(2) || sig_count !== CW'(3)) begin bad++;
      $display("FAIL flush_setup got=%0d/%0d exp=2/3", u_if.tap_idx, sig_count); end
    flush = 1;
    tick();
    flush = 0;
    total++; if (sig_count !== '0 || coef_count !== '0) begin bad++;
      $display("FAIL flush_count got=%0d/%0d exp=0/0", sig_count, coef_count); end
    total++; if (u_if.pair_valid !== 1'b0 || u_if.tap_idx !== '0) begin bad++;
      $display("FAIL flush_state got=%b/%0d exp=0/0", u_if.pair_valid, u_if.tap_idx); end
    total++; if (overflow !== 1'b1) begin bad++;
      $display("FAIL flush_ovf got=%b exp=1", overflow); end
    do_reset();
    total++; if (overflow !== 1'b0) begin bad++;
      $display("FAIL rst_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      flush = ($urandom_range(0, 60) == 0);
      rst = ($urandom_range(0, 150) == 0);
      u_if.pair_ready = $urandom_range(0, 1);
      sig_wr_en = $urandom_range(0, 1); sig_wr_data = $urandom;
      coef_wr_en = $urandom_range(0, 1); coef_wr_data = $urandom;
      tick();
      total++; if (sig_count !== CW'(sq.size()) || coef_count !== CW'(cq.size())) begin bad++;
        $display("FAIL rnd_count i=%0d got=%0d/%0d exp=%0d/%0d", i, sig_count, coef_count, sq.size(), cq.size()); end
      total++; if (sig_full !== (sq.size() == DEPTH) || coef_full !== (cq.size() == DEPTH)) begin bad++;
        $display("FAIL rnd_full i=%0d got=%b%b", i, sig_full, coef_full); end
      total++; if (u_if.pair_valid !== m_pv() || overflow !== m_ovf) begin bad++;
        $display("FAIL rnd_flags i=%0d got=%b/%b exp=%b/%b", i, u_if.pair_valid, overflow, m_pv(), m_ovf); end
      total++; if (u_if.tap_idx !== TW'(m_tap) || u_if.pair_last !== (m_tap == TAPS - 1)) begin bad++;
        $display("FAIL rnd_tap i=%0d got=%0d exp=%0d", i, u_if.tap_idx, m_tap); end
      if (m_pv()) begin
        total++; if (u_if.signal_out !== sq[0] || u_if.coeff_out !== cq[0]) begin bad++;
          $display("FAIL rnd_data i=%0d got=%h/%h exp=%h/%h", i, u_if.signal_out, u_if.coeff_out, sq[0], cq[0]); end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    sig_wr_data = '0; coef_wr_data = '0;
    u_if.pair_ready = 0;
    m_tap = 0; m_ovf = 0;
    #1;
    test_reset();
    test_first_pair();
    test_fill_overflow();
    test_full_pop_write();
    test_stream_taps();
    test_stall();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
